// File: rtl/otter_intr_ctrl.sv
// OTTER machine-mode interrupt and CSR unit.
// Synchronised edge/level IRQ channels, CSR access, trap entry and mret.
module otter_intr_ctrl #(
   parameter int unsigned         NUM_IRQ     = 4,
   parameter int unsigned         SYNC_STAGES = 2,
   parameter logic [NUM_IRQ-1:0]  IRQ_EDGE    = {NUM_IRQ{1'b1}},
   parameter logic [31:0]         RESET_MTVEC = 32'h0
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [NUM_IRQ-1:0] IRQ_IN,
   input  logic [11:0]        CSR_ADDR,
   input  logic [1:0]         CSR_OP,
   input  logic [31:0]        CSR_WDATA,
   output logic [31:0]        CSR_RDATA,
   input  logic               INSTR_BOUNDARY,
   input  logic [31:0]        EPC_IN,
   input  logic               MRET,
   output logic               INTR_TAKEN,
   output logic [31:0]        TRAP_PC,
   output logic               IRQ_PENDING
);

   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MIE     = 12'h304;
   localparam logic [11:0] A_MTVEC   = 12'h305;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;
   localparam logic [11:0] A_MIP     = 12'h344;

   logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
   logic [NUM_IRQ-1:0] irq_s;
   logic [NUM_IRQ-1:0] irq_d_q;
   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] pend_q;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] enabled;
   logic [NUM_IRQ-1:0] win_oh;
   logic [NUM_IRQ-1:0] mie_q;
   logic [3:0]         winner;
   logic [4:0]         cause;
   logic               st_mie_q;
   logic               st_mpie_q;
   logic [31:0]        mtvec_q;
   logic [31:0]        mepc_q;
   logic [31:0]        mcause_q;
   logic [31:0]        mip_rd;
   logic [31:0]        mie_rd;
   logic [31:0]        wv;
   logic [31:0]        base;
   logic               wr_en;
   logic               take;
   logic               sel_mstatus;
   logic               sel_mie;
   logic               sel_mtvec;
   logic               sel_mepc;
   logic               sel_mcause;
   logic               sel_mip;

   assign irq_s   = sync_q[SYNC_STAGES-1];
   assign rise    = irq_s & ~irq_d_q;
   // edge channels use the latched bit, level channels the live level
   assign pending = (pend_q & IRQ_EDGE) | (irq_s & ~IRQ_EDGE);
   assign enabled = pending & mie_q;

   always_comb begin
      winner = '0;
      win_oh = '0;
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         if (enabled[i]) begin
            winner    = 4'(i);
            win_oh    = '0;
            win_oh[i] = 1'b1;
         end
      end
   end

   assign cause       = 5'd16 + {1'b0, winner};
   assign take        = INSTR_BOUNDARY & st_mie_q & (|enabled) & ~MRET;
   assign INTR_TAKEN  = take;
   assign IRQ_PENDING = |enabled;
   assign base        = {mtvec_q[31:2], 2'b00};

   always_comb begin
      if (MRET)
         TRAP_PC = mepc_q;
      else if (mtvec_q[0])
         TRAP_PC = base + {25'b0, cause, 2'b00};
      else
         TRAP_PC = base;
   end

   assign sel_mstatus = (CSR_ADDR == A_MSTATUS);
   assign sel_mie     = (CSR_ADDR == A_MIE);
   assign sel_mtvec   = (CSR_ADDR == A_MTVEC);
   assign sel_mepc    = (CSR_ADDR == A_MEPC);
   assign sel_mcause  = (CSR_ADDR == A_MCAUSE);
   assign sel_mip     = (CSR_ADDR == A_MIP);

   always_comb begin
      mip_rd = '0;
      mie_rd = '0;
      mip_rd[16 +: NUM_IRQ] = pending;
      mie_rd[16 +: NUM_IRQ] = mie_q;
   end

   always_comb begin
      CSR_RDATA = '0;
      unique case (1'b1)
         sel_mstatus: CSR_RDATA = {24'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0};
         sel_mie:     CSR_RDATA = mie_rd;
         sel_mtvec:   CSR_RDATA = mtvec_q;
         sel_mepc:    CSR_RDATA = mepc_q;
         sel_mcause:  CSR_RDATA = mcause_q;
         sel_mip:     CSR_RDATA = mip_rd;
         default:     CSR_RDATA = '0;
      endcase
   end

   always_comb begin
      wv = CSR_RDATA;
      case (CSR_OP)
         2'b01:   wv = CSR_WDATA;
         2'b10:   wv = CSR_RDATA | CSR_WDATA;
         2'b11:   wv = CSR_RDATA & ~CSR_WDATA;
         default: wv = CSR_RDATA;
      endcase
   end

   assign wr_en = (CSR_OP == 2'b01) | (CSR_OP[1] & (|CSR_WDATA));

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int s = 0; s < int'(SYNC_STAGES); s++)
            sync_q[s] <= '0;
         irq_d_q <= '0;
         pend_q  <= '0;
      end else begin
         sync_q[0] <= IRQ_IN;
         for (int s = 1; s < int'(SYNC_STAGES); s++)
            sync_q[s] <= sync_q[s-1];
         irq_d_q <= irq_s;
         // a fresh edge beats the take clear
         pend_q  <= ((pend_q & ~(take ? win_oh : '0)) | rise) & IRQ_EDGE;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         st_mie_q  <= 1'b0;
         st_mpie_q <= 1'b0;
         mie_q     <= '0;
         mtvec_q   <= RESET_MTVEC & ~32'h2;
         mepc_q    <= '0;
         mcause_q  <= '0;
      end else begin
         if (wr_en) begin
            unique case (1'b1)
               sel_mstatus: begin
                  st_mie_q  <= wv[3];
                  st_mpie_q <= wv[7];
               end
               sel_mie:    mie_q    <= wv[16 +: NUM_IRQ];
               sel_mtvec:  mtvec_q  <= wv & ~32'h2;
               sel_mepc:   mepc_q   <= wv & ~32'h3;
               sel_mcause: mcause_q <= wv;
               default: ;
            endcase
         end
         if (MRET) begin
            st_mie_q  <= st_mpie_q;
            st_mpie_q <= 1'b1;
         end
         // trap entry overrides any same-cycle CSR write
         if (take) begin
            mepc_q    <= EPC_IN & ~32'h3;
            mcause_q  <= 32'h8000_0000 | {27'b0, cause};
            st_mpie_q <= st_mie_q;
            st_mie_q  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Directed bench for otter_intr_ctrl.
// Channel 1 is level, the rest edge; mtvec resets to 0x100.
module tb_otter_intr_ctrl;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [3:0]  IRQ_IN;
   logic [11:0] CSR_ADDR;
   logic [1:0]  CSR_OP;
   logic [31:0] CSR_WDATA;
   logic [31:0] CSR_RDATA;
   logic        INSTR_BOUNDARY;
   logic [31:0] EPC_IN;
   logic        MRET;
   logic        INTR_TAKEN;
   logic [31:0] TRAP_PC;
   logic        IRQ_PENDING;

   int n_cmp = 0;
   int n_bad = 0;

   otter_intr_ctrl #(
      .NUM_IRQ     (4),
      .SYNC_STAGES (2),
      .IRQ_EDGE    (4'b1101),
      .RESET_MTVEC (32'h100)
   ) dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .IRQ_IN         (IRQ_IN),
      .CSR_ADDR       (CSR_ADDR),
      .CSR_OP         (CSR_OP),
      .CSR_WDATA      (CSR_WDATA),
      .CSR_RDATA      (CSR_RDATA),
      .INSTR_BOUNDARY (INSTR_BOUNDARY),
      .EPC_IN         (EPC_IN),
      .MRET           (MRET),
      .INTR_TAKEN     (INTR_TAKEN),
      .TRAP_PC        (TRAP_PC),
      .IRQ_PENDING    (IRQ_PENDING)
   );

   always #50 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic rd(input string tag, input logic [11:0] a,
                     input logic [31:0] exp);
      CSR_ADDR = a;
      CSR_OP   = 2'b00;
      #1;
      chk(tag, CSR_RDATA, exp);
   endtask

   task automatic wr(input logic [11:0] a, input logic [1:0] op,
                     input logic [31:0] d);
      CSR_ADDR  = a;
      CSR_OP    = op;
      CSR_WDATA = d;
      tick();
      CSR_OP    = 2'b00;
      CSR_WDATA = '0;
   endtask

   task automatic pulse0();
      IRQ_IN = 4'b0001;
      tick();
      IRQ_IN = 4'b0000;
      tick();
      tick();
   endtask

   initial begin
      RESET = 1'b1;
      IRQ_IN = '0;
      CSR_ADDR = '0;
      CSR_OP = '0;
      CSR_WDATA = '0;
      INSTR_BOUNDARY = 1'b0;
      EPC_IN = '0;
      MRET = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      rd("rst mtvec", 12'h305, 32'h100);
      rd("rst mstatus", 12'h300, 32'h0);
      rd("rst mie", 12'h304, 32'h0);
      rd("rst mepc", 12'h341, 32'h0);
      rd("rst mcause", 12'h342, 32'h0);
      rd("rst mip", 12'h344, 32'h0);
      chk("rst taken", 32'(INTR_TAKEN), 32'h0);
      chk("rst pend", 32'(IRQ_PENDING), 32'h0);
      RESET = 1'b0;
      tick();

      wr(12'h123, 2'b01, 32'hffff_ffff);
      rd("unmapped", 12'h123, 32'h0);
      wr(12'h344, 2'b01, 32'hffff_ffff);
      rd("mip ro", 12'h344, 32'h0);
      wr(12'h300, 2'b01, 32'hffff_ffff);
      rd("mstatus mask", 12'h300, 32'h88);
      wr(12'h300, 2'b01, 32'h0);

      wr(12'h304, 2'b01, 32'h0001_0000);
      rd("mie wr", 12'h304, 32'h0001_0000);
      wr(12'h300, 2'b10, 32'h8);
      rd("mstatus set", 12'h300, 32'h8);
      wr(12'h304, 2'b11, 32'h0);
      rd("clr zero", 12'h304, 32'h0001_0000);
      INSTR_BOUNDARY = 1'b1;
      EPC_IN = 32'h204;
      IRQ_IN = 4'b0001;
      tick();
      IRQ_IN = 4'b0000;
      chk("edge c1", 32'(INTR_TAKEN), 32'h0);
      tick();
      chk("edge c2", 32'(INTR_TAKEN), 32'h0);
      tick();
      chk("edge c3", 32'(INTR_TAKEN), 32'h1);
      chk("edge pc", TRAP_PC, 32'h100);
      tick();
      INSTR_BOUNDARY = 1'b0;
      rd("edge mepc", 12'h341, 32'h204);
      rd("edge mcause", 12'h342, 32'h8000_0010);
      rd("edge mstatus", 12'h300, 32'h80);
      rd("edge mip", 12'h344, 32'h0);

      MRET = 1'b1;
      #1;
      chk("mret pc", TRAP_PC, 32'h204);
      tick();
      MRET = 1'b0;
      rd("mret mstatus", 12'h300, 32'h88);

      wr(12'h305, 2'b01, 32'h103);
      rd("mtvec bit1", 12'h305, 32'h101);
      wr(12'h304, 2'b01, 32'h0005_0000);
      IRQ_IN = 4'b0101;
      tick();
      tick();
      tick();
      rd("vec mip", 12'h344, 32'h0005_0000);
      chk("vec pend", 32'(IRQ_PENDING), 32'h1);
      INSTR_BOUNDARY = 1'b1;
      EPC_IN = 32'h300;
      #1;
      chk("vec take0", 32'(INTR_TAKEN), 32'h1);
      chk("vec pc0", TRAP_PC, 32'h140);
      tick();
      INSTR_BOUNDARY = 1'b0;
      rd("vec mcause0", 12'h342, 32'h8000_0010);
      rd("vec mip2", 12'h344, 32'h0004_0000);
      IRQ_IN = 4'b0000;
      MRET = 1'b1;
      tick();
      MRET = 1'b0;
      INSTR_BOUNDARY = 1'b1;
      #1;
      chk("vec take2", 32'(INTR_TAKEN), 32'h1);
      chk("vec pc2", TRAP_PC, 32'h148);
      tick();
      INSTR_BOUNDARY = 1'b0;
      rd("vec mcause2", 12'h342, 32'h8000_0012);
      rd("vec mepc", 12'h341, 32'h300);
      rd("vec mip0", 12'h344, 32'h0);

      wr(12'h304, 2'b01, 32'h0002_0000);
      MRET = 1'b1;
      tick();
      MRET = 1'b0;
      IRQ_IN = 4'b0010;
      tick();
      rd("lvl lat1", 12'h344, 32'h0);
      tick();
      rd("lvl lat2", 12'h344, 32'h0002_0000);
      INSTR_BOUNDARY = 1'b1;
      EPC_IN = 32'h500;
      #1;
      chk("lvl take", 32'(INTR_TAKEN), 32'h1);
      chk("lvl pc", TRAP_PC, 32'h144);
      tick();
      rd("lvl mcause", 12'h342, 32'h8000_0011);
      rd("lvl held", 12'h344, 32'h0002_0000);
      chk("lvl masked", 32'(INTR_TAKEN), 32'h0);
      MRET = 1'b1;
      #1;
      chk("lvl mret", 32'(INTR_TAKEN), 32'h0);
      tick();
      MRET = 1'b0;
      #1;
      chk("lvl retrap", 32'(INTR_TAKEN), 32'h1);
      tick();
      INSTR_BOUNDARY = 1'b0;
      IRQ_IN = 4'b0000;
      MRET = 1'b1;
      tick();
      MRET = 1'b0;
      rd("lvl drop1", 12'h344, 32'h0002_0000);
      tick();
      rd("lvl drop2", 12'h344, 32'h0);
      INSTR_BOUNDARY = 1'b1;
      #1;
      chk("lvl none", 32'(INTR_TAKEN), 32'h0);
      chk("lvl npend", 32'(IRQ_PENDING), 32'h0);
      INSTR_BOUNDARY = 1'b0;

      wr(12'h300, 2'b01, 32'h0);
      wr(12'h305, 2'b01, 32'h100);
      wr(12'h304, 2'b01, 32'h0001_0000);
      pulse0();
      rd("rmw mip", 12'h344, 32'h0001_0000);
      INSTR_BOUNDARY = 1'b1;
      EPC_IN = 32'h407;
      CSR_ADDR = 12'h300;
      CSR_OP = 2'b10;
      CSR_WDATA = 32'h8;
      #1;
      chk("rmw rdata", CSR_RDATA, 32'h0);
      chk("rmw notake", 32'(INTR_TAKEN), 32'h0);
      tick();
      CSR_ADDR = 12'h342;
      CSR_OP = 2'b01;
      CSR_WDATA = 32'h55;
      #1;
      chk("rmw take", 32'(INTR_TAKEN), 32'h1);
      chk("rmw pc", TRAP_PC, 32'h100);
      tick();
      CSR_OP = 2'b00;
      CSR_WDATA = '0;
      INSTR_BOUNDARY = 1'b0;
      rd("take beats wr", 12'h342, 32'h8000_0010);
      rd("mepc mask", 12'h341, 32'h404);
      rd("rmw mstatus", 12'h300, 32'h80);

      pulse0();
      wr(12'h300, 2'b10, 32'h8);
      INSTR_BOUNDARY = 1'b1;
      MRET = 1'b1;
      EPC_IN = 32'h600;
      #1;
      chk("mret supp", 32'(INTR_TAKEN), 32'h0);
      chk("mret supp pc", TRAP_PC, 32'h404);
      tick();
      MRET = 1'b0;
      rd("mret mie", 12'h300, 32'h88);
      chk("after mret", 32'(INTR_TAKEN), 32'h1);
      tick();
      INSTR_BOUNDARY = 1'b0;
      rd("after mepc", 12'h341, 32'h600);
      rd("after mcause", 12'h342, 32'h8000_0010);

      pulse0();
      rd("pre rst mip", 12'h344, 32'h0001_0000);
      RESET = 1'b1;
      #1;
      chk("mid rst pend", 32'(IRQ_PENDING), 32'h0);
      rd("mid rst mip", 12'h344, 32'h0);
      rd("mid rst mtvec", 12'h305, 32'h100);
      tick();
      RESET = 1'b0;
      INSTR_BOUNDARY = 1'b1;
      wr(12'h304, 2'b01, 32'h0001_0000);
      wr(12'h300, 2'b10, 32'h8);
      tick();
      tick();
      chk("post rst take", 32'(INTR_TAKEN), 32'h0);
      rd("post rst mepc", 12'h341, 32'h0);
      rd("post rst mip", 12'h344, 32'h0);
      INSTR_BOUNDARY = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
